pc_branch_ctrl: RTL and testbench
=================================

// Module: pc_branch_ctrl
// PURPOSE
//  Program-counter and branch-resolution stage of the RISC-V core. Consumes the
//  equality flag from the branch comparator plus decode controls; produces the
//  fetch PC, the front-end flush, and a fetch-valid qualifier.
//  Owns the only PC register in the core and the post-redirect flush sequence.
// PARAMETERS
//  WIDTH         32           PC/immediate width (bits)
//  RESET_VEC     32'h0000_0000 PC value loaded on reset
//  FLUSH_CYCLES  2            cycles flush_o stays high after a redirect (>=1)
//  CNT_W         16           stats counter width (BRANCH_STATS_EN only)
// PORTS
//  clk             in   1        core clock, rising edge
//  rst             in   1        asynchronous, active-high reset
//  stall_i         in   1        hold PC (downstream not ready)
//  branch_i        in   1        EX instr is a conditional branch
//  bne_sel_i       in   1        0 = BEQ, 1 = BNE
//  beq_i           in   1        equality flag from branch comparator
//  jump_i          in   1        EX instr is JAL (unconditional)
//  ex_pc_i         in   WIDTH    PC of the EX-stage instruction
//  imm_i           in   WIDTH    sign-extended branch/jump offset
//  pc_o            out  WIDTH    current fetch PC (registered)
//  fetch_valid_o   out  1        fetch at pc_o is architecturally valid
//  flush_o         out  1        kill IF/ID contents (registered)
//  redirect_o      out  1        combinational: redirect taken this cycle
//  br_total_o      out  CNT_W    branches resolved (BRANCH_STATS_EN only)
//  br_taken_o      out  CNT_W    branches taken (BRANCH_STATS_EN only)
// BEHAVIOUR
//  Reset (async, any time, incl. mid-flush): pc_o=RESET_VEC, fetch_valid_o=0,
//   flush_o=0, flush count=0, state=BOOT, stats=0.
//  taken = jump_i | (branch_i & (beq_i ^ bne_sel_i)); redirect_o = taken & state==RUN.
//  target = (ex_pc_i + imm_i) mod 2^WIDTH, bits[1:0] forced to 0.
//  FSM:
//   BOOT : pc held; fetch_valid_o=0; -> RUN next cycle (always, ignores stall).
//   RUN  : fetch_valid_o=1. redirect -> pc<=target, flush_o<=1, cnt<=FLUSH_CYCLES-1,
//          -> FLUSH. Redirect wins over stall_i. Else !stall_i -> pc<=pc+4 (wraps
//          at 2^WIDTH); stall_i -> pc held.
//   FLUSH: flush_o=1, fetch_valid_o=1. branch_i/jump_i ignored (wrong-path instrs).
//          pc advances +4 unless stall_i. cnt==0 -> flush_o<=0, -> RUN; else cnt-1.
//          Stall does not extend the flush window.
//  Latency: redirect in cycle N -> pc_o=target and flush_o=1 in N+1; flush_o
//   high exactly FLUSH_CYCLES cycles.
//  jump_i and branch_i together: jump wins (taken=1, same target formula).
//  Illegal state encoding -> BOOT.
// CONFIGURATION
//  BRANCH_STATS_EN defined: br_total_o increments on each RUN cycle with branch_i
//   or jump_i; br_taken_o on each redirect; both saturate at 2^CNT_W-1; reset
//   to 0.
//  Not defined: stats ports absent, no counter logic. All other behaviour
//   identical.
// STRUCTURE
//  pc_pkg: state encoding (BOOT/RUN/FLUSH), PC_INC=4, ALIGN_MASK.
//  Sub-module branch_stats_cnt (two saturating counters), instantiated only under
//   BRANCH_STATS_EN. FSM, PC register and target adder stay in this module.
// TESTING
//  1 rst pulse mid-run, FLUSH_CYCLES=2 -> pc_o=0, fetch_valid_o=0 same cycle;
//    cycle after release fetch_valid_o=1, then pc_o 0,4,8.
//  2 RUN, pc=0x10, branch_i=1,bne_sel_i=0,beq_i=1,ex_pc_i=0x8,imm_i=0x20 ->
//    redirect_o=1; next cycle pc_o=0x28, flush_o=1 for exactly 2 cycles.
//  3 BNE with beq_i=1 -> no redirect, pc +4; BNE with beq_i=0, imm=-8,
//    ex_pc=0x40 -> pc_o=0x38.
//  4 Redirect with stall_i=1 -> pc_o=target; stall during FLUSH -> pc held,
//    flush_o still drops after 2 cycles.
//  5 branch_i=1 taken during FLUSH -> ignored; pc=0xFFFF_FFFC no stall ->
//    pc_o=0; imm giving odd target 0x103 -> pc_o=0x100.
//  6 BRANCH_STATS_EN, CNT_W=2: 5 taken branches (spaced past flush) ->
//    br_total_o=br_taken_o=3 (saturated).

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the PC / branch-resolution stage: FSM state encoding,
// PC increment and target alignment mask.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    localparam int         PC_INC     = 4;
    // Applied to target bits [1:0]; all-zero forces word alignment.
    localparam logic [1:0] ALIGN_MASK = 2'b00;

endpackage

// File: rtl/pc_branch_ctrl_stats.sv
// branch_stats_cnt: two saturating event counters (branches resolved, branches
// taken). Only instantiated when BRANCH_STATS_EN is defined.
module branch_stats_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_total,
    input  logic             inc_taken,
    output logic [CNT_W-1:0] br_total,
    output logic [CNT_W-1:0] br_taken
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_total <= '0;
            br_taken <= '0;
        end else begin
            if (inc_total && (br_total != CNT_MAX)) br_total <= br_total + CNT_W'(1);
            if (inc_taken && (br_taken != CNT_MAX)) br_taken <= br_taken + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_branch_ctrl.sv
// PC register, branch resolution and post-redirect flush sequencing.
// Optional branch statistics counters are built when BRANCH_STATS_EN is defined.
//
// state | meaning
// BOOT  | first cycle after reset, PC held, fetch not yet valid
// RUN   | normal fetch; branches/jumps resolved and may redirect
// FLUSH | wrong-path window after a redirect; branch inputs ignored
module pc_branch_ctrl
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VEC    = '0,
    parameter int               FLUSH_CYCLES = 2,
    parameter int               CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             bne_sel_i,
    input  logic             beq_i,
    input  logic             jump_i,
    input  logic [WIDTH-1:0] ex_pc_i,
    input  logic [WIDTH-1:0] imm_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             fetch_valid_o,
    output logic             flush_o,
`ifdef BRANCH_STATS_EN
    output logic [CNT_W-1:0] br_total_o,
    output logic [CNT_W-1:0] br_taken_o,
`endif
    output logic             redirect_o
);

    localparam int CNT_FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    if (FLUSH_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
        $error("pc_branch_ctrl: FLUSH_CYCLES and CNT_W must be >= 1");
    end

    state_t            state;
    logic [CNT_FW-1:0] cnt;
    logic              taken;
    logic [WIDTH-1:0]  sum;
    logic [WIDTH-1:0]  target;
    logic [WIDTH-1:0]  pc_inc;

    // A jump alone makes taken true, so it also wins over a concurrent branch.
    assign taken      = jump_i | (branch_i & (beq_i ^ bne_sel_i));
    assign redirect_o = taken & (state == ST_RUN);
    assign sum        = ex_pc_i + imm_i;
    assign target     = {sum[WIDTH-1:2], sum[1:0] & ALIGN_MASK};
    assign pc_inc     = pc_o + WIDTH'(PC_INC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_BOOT;
            pc_o          <= RESET_VEC;
            fetch_valid_o <= 1'b0;
            flush_o       <= 1'b0;
            cnt           <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state         <= ST_RUN;
                    fetch_valid_o <= 1'b1;
                end
                ST_RUN: begin
                    fetch_valid_o <= 1'b1;
                    if (redirect_o) begin
                        pc_o    <= target;
                        flush_o <= 1'b1;
                        cnt     <= CNT_FW'(FLUSH_CYCLES - 1);
                        state   <= ST_FLUSH;
                    end else if (!stall_i) begin
                        pc_o <= pc_inc;
                    end
                end
                ST_FLUSH: begin
                    fetch_valid_o <= 1'b1;
                    if (!stall_i) pc_o <= pc_inc;
                    // The window counts cycles, not accepted fetches.
                    if (cnt == '0) begin
                        flush_o <= 1'b0;
                        state   <= ST_RUN;
                    end else begin
                        cnt <= cnt - CNT_FW'(1);
                    end
                end
                default: begin
                    state         <= ST_BOOT;
                    fetch_valid_o <= 1'b0;
                    flush_o       <= 1'b0;
                    cnt           <= '0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    branch_stats_cnt #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk       (clk),
        .rst       (rst),
        .inc_total ((state == ST_RUN) & (branch_i | jump_i)),
        .inc_taken (redirect_o),
        .br_total  (br_total_o),
        .br_taken  (br_taken_o)
    );
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Randomized and directed bench for pc_branch_ctrl against a cycle-level
// behavioural model (remaining-flush count plus PC arithmetic).
module tb_pc_branch_ctrl;

    localparam int FC = 2;
`ifdef BRANCH_STATS_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0, branch_i = 1'b0, bne_sel_i = 1'b0, beq_i = 1'b0, jump_i = 1'b0;
    logic [31:0] ex_pc_i = '0, imm_i = '0;
    logic [31:0] pc_o;
    logic        fetch_valid_o, flush_o, redirect_o;
`ifdef BRANCH_STATS_EN
    logic [CW-1:0] br_total_o, br_taken_o;
`endif

    int total = 0;
    int bad   = 0;

    bit          m_booted;
    int          m_flush_left;
    logic [31:0] m_pc;
    int          m_total, m_taken;

    always #5 clk = ~clk;

    pc_branch_ctrl #(
        .WIDTH        (32),
        .RESET_VEC    (32'h0000_0000),
        .FLUSH_CYCLES (FC),
        .CNT_W        (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .branch_i      (branch_i),
        .bne_sel_i     (bne_sel_i),
        .beq_i         (beq_i),
        .jump_i        (jump_i),
        .ex_pc_i       (ex_pc_i),
        .imm_i         (imm_i),
        .pc_o          (pc_o),
        .fetch_valid_o (fetch_valid_o),
        .flush_o       (flush_o),
`ifdef BRANCH_STATS_EN
        .br_total_o    (br_total_o),
        .br_taken_o    (br_taken_o),
`endif
        .redirect_o    (redirect_o)
    );

    function automatic logic [31:0] m_target();
        return (ex_pc_i + imm_i) & 32'hFFFF_FFFC;
    endfunction

    function automatic bit m_redirect();
        bit tk;
        tk = jump_i || (branch_i && (beq_i != bne_sel_i));
        return m_booted && (m_flush_left == 0) && tk;
    endfunction

    task automatic model_reset();
        m_booted = 0; m_flush_left = 0; m_pc = 32'h0; m_total = 0; m_taken = 0;
    endtask

    task automatic drive(input bit st, br, bne, beq, jmp, input logic [31:0] ex, im);
        stall_i = st; branch_i = br; bne_sel_i = bne; beq_i = beq; jump_i = jmp;
        ex_pc_i = ex; imm_i = im;
    endtask

    // One clock: model consumes the inputs held across the rising edge.
    task automatic advance();
        bit redir;
        @(posedge clk);
        redir = m_redirect();
        if (!m_booted) begin
            m_booted = 1;
        end else if (m_flush_left > 0) begin
            if (!stall_i) m_pc = m_pc + 32'd4;
            m_flush_left--;
        end else begin
            if (branch_i || jump_i) m_total = (m_total < (1 << CW) - 1) ? m_total + 1 : m_total;
            if (redir) begin
                m_taken = (m_taken < (1 << CW) - 1) ? m_taken + 1 : m_taken;
                m_pc = m_target();
                m_flush_left = FC;
            end else if (!stall_i) begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clk); #1;
        total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=%h", pc_o, 32'h0); end
        total++; if (fetch_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", fetch_valid_o); end
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b exp=0", flush_o); end
`ifdef BRANCH_STATS_EN
        total++; if (br_total_o !== '0 || br_taken_o !== '0) begin bad++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", br_total_o, br_taken_o); end
`endif
        @(negedge clk);
        rst = 1'b0;
        advance();
        total++; if (fetch_valid_o !== 1'b1 || pc_o !== 32'h0) begin bad++; $display("FAIL boot got valid=%b pc=%h exp valid=1 pc=0", fetch_valid_o, pc_o); end
        advance();
        total++; if (pc_o !== 32'h4) begin bad++; $display("FAIL run_pc4 got=%h exp=%h", pc_o, 32'h4); end
        advance();
        total++; if (pc_o !== 32'h8) begin bad++; $display("FAIL run_pc8 got=%h exp=%h", pc_o, 32'h8); end
        // asynchronous pulse between edges
        #2 rst = 1'b1; model_reset(); #1;
        total++; if (pc_o !== 32'h0 || fetch_valid_o !== 1'b0) begin bad++; $display("FAIL async_rst got pc=%h valid=%b exp pc=0 valid=0", pc_o, fetch_valid_o); end
        @(negedge clk);
        rst = 1'b0;
        advance();
        total++; if (fetch_valid_o !== 1'b1 || pc_o !== 32'h0) begin bad++; $display("FAIL reboot got valid=%b pc=%h exp valid=1 pc=0", fetch_valid_o, pc_o); end
        advance(); advance();
        total++; if (pc_o !== 32'h8) begin bad++; $display("FAIL reboot_pc8 got=%h exp=%h", pc_o, 32'h8); end
    endtask

    task automatic test_beq_taken();
        advance(); advance();
        total++; if (pc_o !== 32'h10) begin bad++; $display("FAIL beq_start got=%h exp=%h", pc_o, 32'h10); end
        drive(0, 1, 0, 1, 0, 32'h8, 32'h20); #1;
        total++; if (redirect_o !== 1'b1) begin bad++; $display("FAIL beq_redirect got=%b exp=1", redirect_o); end
        advance();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        total++; if (pc_o !== 32'h28 || flush_o !== 1'b1) begin bad++; $display("FAIL beq_target got pc=%h flush=%b exp pc=28 flush=1", pc_o, flush_o); end
        advance();
        total++; if (pc_o !== 32'h2c || flush_o !== 1'b1) begin bad++; $display("FAIL beq_flush2 got pc=%h flush=%b exp pc=2c flush=1", pc_o, flush_o); end
        advance();
        total++; if (pc_o !== 32'h30 || flush_o !== 1'b0) begin bad++; $display("FAIL beq_flush_end got pc=%h flush=%b exp pc=30 flush=0", pc_o, flush_o); end
    endtask

    task automatic test_bne();
        drive(0, 1, 1, 1, 0, 32'h40, 32'hFFFF_FFF8); #1;
        total++; if (redirect_o !== 1'b0) begin bad++; $display("FAIL bne_eq_redirect got=%b exp=0", redirect_o); end
        advance();
        total++; if (pc_o !== 32'h34 || flush_o !== 1'b0) begin bad++; $display("FAIL bne_eq_pc got pc=%h flush=%b exp pc=34 flush=0", pc_o, flush_o); end
        drive(0, 1, 1, 0, 0, 32'h40, 32'hFFFF_FFF8); #1;
        total++; if (redirect_o !== 1'b1) begin bad++; $display("FAIL bne_ne_redirect got=%b exp=1", redirect_o); end
        advance();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        total++; if (pc_o !== 32'h38) begin bad++; $display("FAIL bne_target got=%h exp=%h", pc_o, 32'h38); end
        advance(); advance();
        total++; if (pc_o !== 32'h40 || flush_o !== 1'b0) begin bad++; $display("FAIL bne_after got pc=%h flush=%b exp pc=40 flush=0", pc_o, flush_o); end
    endtask

    task automatic test_stall();
        drive(1, 0, 0, 0, 1, 32'h200, 32'h10); #1;
        total++; if (redirect_o !== 1'b1) begin bad++; $display("FAIL stall_redirect got=%b exp=1", redirect_o); end
        advance();
        drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
        total++; if (pc_o !== 32'h210 || flush_o !== 1'b1) begin bad++; $display("FAIL stall_target got pc=%h flush=%b exp pc=210 flush=1", pc_o, flush_o); end
        advance();
        total++; if (pc_o !== 32'h210 || flush_o !== 1'b1) begin bad++; $display("FAIL stall_hold got pc=%h flush=%b exp pc=210 flush=1", pc_o, flush_o); end
        advance();
        total++; if (pc_o !== 32'h210 || flush_o !== 1'b0) begin bad++; $display("FAIL stall_flush_end got pc=%h flush=%b exp pc=210 flush=0", pc_o, flush_o); end
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic test_flush_ignore_wrap();
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFF0, 32'h8);
        advance();
        drive(0, 1, 0, 1, 0, 32'h0, 32'h1000); #1;
        total++; if (redirect_o !== 1'b0) begin bad++; $display("FAIL flush_ignore_redirect got=%b exp=0", redirect_o); end
        advance();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        total++; if (pc_o !== 32'hFFFF_FFFC || flush_o !== 1'b1) begin bad++; $display("FAIL flush_ignore_pc got pc=%h flush=%b exp pc=fffffffc flush=1", pc_o, flush_o); end
        advance();
        total++; if (pc_o !== 32'h0 || flush_o !== 1'b0) begin bad++; $display("FAIL wrap got pc=%h flush=%b exp pc=0 flush=0", pc_o, flush_o); end
        // jump together with a not-taken branch: jump wins, odd target aligned
        drive(0, 1, 1, 1, 1, 32'h100, 32'h3);
        advance();
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
        total++; if (pc_o !== 32'h100) begin bad++; $display("FAIL align got=%h exp=%h", pc_o, 32'h100); end
        advance();
        #2 rst = 1'b1; model_reset(); #1;
        total++; if (pc_o !== 32'h0 || flush_o !== 1'b0 || fetch_valid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_flush got pc=%h flush=%b valid=%b exp 0/0/0", pc_o, flush_o, fetch_valid_o); end
        @(negedge clk);
        rst = 1'b0;
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                #2 rst = 1'b1; model_reset(); #1;
                total++; if (pc_o !== 32'h0 || fetch_valid_o !== 1'b0 || flush_o !== 1'b0) begin bad++; $display("FAIL rnd_rst got pc=%h valid=%b flush=%b", pc_o, fetch_valid_o, flush_o); end
                @(negedge clk);
                rst = 1'b0;
            end
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 8) == 0, $urandom,
                  ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 511)) - 256));
            #1;
            total++; if (redirect_o !== m_redirect()) begin bad++; $display("FAIL rnd_redirect cyc=%0d got=%b exp=%b", i, redirect_o, m_redirect()); end
            total++; if (pc_o !== m_pc) begin bad++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, pc_o, m_pc); end
            total++; if (flush_o !== (m_flush_left > 0)) begin bad++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", i, flush_o, m_flush_left > 0); end
            total++; if (fetch_valid_o !== m_booted) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, fetch_valid_o, m_booted); end
`ifdef BRANCH_STATS_EN
            total++; if (br_total_o !== CW'(m_total) || br_taken_o !== CW'(m_taken)) begin bad++; $display("FAIL rnd_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", i, br_total_o, br_taken_o, m_total, m_taken); end
`endif
            advance();
        end
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats_sat();
        #2 rst = 1'b1; model_reset();
        @(negedge clk);
        rst = 1'b0;
        advance();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 1, 0, 32'h1000, 32'h40);
            advance();
            drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
            advance(); advance();
        end
        total++; if (br_total_o !== 2'd3 || br_taken_o !== 2'd3) begin bad++; $display("FAIL stats_sat got=%0d/%0d exp=3/3", br_total_o, br_taken_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_beq_taken();
        test_bne();
        test_stall();
        test_flush_ignore_wrap();
        test_random();
`ifdef BRANCH_STATS_EN
        test_stats_sat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
